wbr_access_ctrl: RTL and testbench
==================================

Name: wbr_access_ctrl

Overview:
- Host-side initiator for the IEEE 1500 wrapper boundary register (WBR) chain.
- Drives the WBR's serial input and its scan/hold enables (wse_outputs, hold_outputs). Samples the WBR's serial output.
- Performs capture, shift, and release operations requested by a test sequencer.
- Sits between the chip-level test sequencer and the core wrapper. Lets a bench or on-chip controller load a full WBR vector and read back captured core responses in one handshake.

Parameters:
- WBR_LEN, 7, number of cells in the WBR chain, >= 2.
- CNT_W, 4, shift counter width; must satisfy 2**CNT_W > WBR_LEN.

Ports:
- CLK  input  1  single clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request pulse; accepted only in IDLE.
- op  input  2  operation, sampled with start: 00 SHIFT, 01 CAPTURE_SHIFT, 10 CAPTURE, 11 RELEASE.
- wdata  input  WBR_LEN  vector to load; sampled with start.
- rdata  output  WBR_LEN  vector shifted out of the chain.
- busy  output  1  high from the cycle after accept until DONE inclusive.
- done  output  1  one-cycle completion pulse.
- wse_outputs  output  1  WBR shift enable.
- hold_outputs  output  1  WBR hold enable.
- WPSI0  output  1  serial data into the WBR chain.
- WPSO0  input  1  serial data out of the WBR chain.

Behaviour:
- Interface: one clock, CLK; reset is synchronous and active-high, port reset.
- All outputs are registered.
- Reset values: state=IDLE, wse_outputs=0, hold_outputs=0, WPSI0=0, rdata=0, busy=0, done=0, counter=0.
- States: IDLE, CAPT, SHIFT, DONE.
- WBR cell modes, as seen by the chain:
  - wse=1: shift.
  - wse=0, hold=1: hold.
  - wse=0, hold=0: capture/functional.
- IDLE:
  - wse=0; hold_outputs keeps its last value.
  - On start=1, latch op and wdata into the shift register.
  - op 00 -> SHIFT.
  - op 01 or 10 -> CAPT.
  - op 11 -> DONE, with hold_outputs<=0.
- CAPT (exactly 1 cycle):
  - wse=0, hold=0; the WBR captures CoreOut/pin values at the end of this cycle.
  - Next state: SHIFT for op 01; DONE for op 10.
- SHIFT (exactly WBR_LEN cycles):
  - wse=1, hold=1.
  - WPSI0 = current MSB of the shift register; the MSB of wdata is presented first.
  - At each rising edge with wse=1:
    - WPSO0 is sampled into the LSB of the capture register, which shifts left.
    - The transmit register shifts left.
  - Counter counts 0..WBR_LEN-1; leave SHIFT when counter==WBR_LEN-1.
  - Resulting chain content: wdata[WBR_LEN-1] lands in the cell adjacent to WPSO0; wdata[0] lands in the cell adjacent to WPSI0.
  - Resulting rdata: rdata[WBR_LEN-1] is the pre-shift content of the cell adjacent to WPSO0.
- DONE (1 cycle):
  - done=1, busy=1, wse=0.
  - hold_outputs=1 for ops 00/01/10; hold_outputs=0 for op 11.
  - rdata is updated on entry to DONE for ops 00/01 only; unchanged for 10/11.
  - Next state: IDLE.
- Latencies from the start edge to the done pulse:
  - op 00: WBR_LEN+1 cycles.
  - op 01: WBR_LEN+2 cycles.
  - op 10: 2 cycles.
  - op 11: 1 cycle.
- start while busy is ignored: no queueing, no effect on the current operation.
- start on the same cycle as done is ignored; start is accepted only from IDLE.
- op/wdata changes after acceptance have no effect.
- Reset asserted mid-operation: on the next edge, all outputs return to reset values.
  - The WBR chain is left partially shifted; no done pulse is issued.
- wse_outputs and hold_outputs never change to an undefined combination: wse=1 implies hold=1.
- Counter wrap: the counter is cleared on SHIFT entry and never exceeds WBR_LEN-1.

Test Plan:
- Reset check: after reset, with WBR_LEN=7 -> wse=0, hold=0, busy=0, done=0, rdata=7'h00, WPSI0=0.
- SHIFT 7'b1011001, with WPSO0 driven by a 7-cell behavioural chain preloaded with 7'b0110101:
  - WPSI0 sequence 1,0,1,1,0,0,1; wse high for exactly 7 cycles.
  - done 8 cycles after start; rdata=7'b0110101; chain now holds 7'b1011001; hold=1.
- CAPTURE_SHIFT, core outputs forced to 7'b1110000:
  - exactly one cycle with wse=0, hold=0, then 7 shift cycles.
  - done at cycle 9; rdata=7'b1110000.
- Back-to-back and ignored start:
  - start pulsed again during SHIFT and on the done cycle -> ignored: no extra shifting, busy unchanged.
  - A third start one cycle after done -> accepted.
- RELEASE after SHIFT -> hold drops to 0 on the done cycle (1 cycle after start); rdata unchanged.
- Reset at shift cycle 3 of 7 -> next edge: wse=0, hold=0, busy=0, no done pulse.
  - A new SHIFT then completes normally with correct rdata.

Source files
------------

// File: rtl/wbr_access_ctrl.sv
// Host-side initiator for an IEEE 1500 wrapper boundary register chain.
// Performs SHIFT, CAPTURE_SHIFT, CAPTURE and RELEASE operations on the WBR
// through WPSI0/WPSO0 and the wse/hold enables. All outputs are registered.
module wbr_access_ctrl #(
  parameter int unsigned WBR_LEN = 7,
  parameter int unsigned CNT_W   = 4
) (
  input  logic               CLK,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [WBR_LEN-1:0] wdata,
  output logic [WBR_LEN-1:0] rdata,
  output logic               busy,
  output logic               done,
  output logic               wse_outputs,
  output logic               hold_outputs,
  output logic               WPSI0,
  input  logic               WPSO0
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAPT  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] OP_SHIFT   = 2'b00;
  localparam logic [1:0] OP_CSHIFT  = 2'b01;
  localparam logic [1:0] OP_CAPTURE = 2'b10;
  localparam logic [1:0] OP_RELEASE = 2'b11;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WBR_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t             state_q, state_d;
  logic [1:0]         op_q, op_d;
  logic [WBR_LEN-1:0] tx_q, tx_d;
  logic [WBR_LEN-1:0] cap_q, cap_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WBR_LEN-1:0] rdata_d;
  logic               busy_d, done_d, wse_d, hold_d, wpsi_d;

  // State and output registers, synchronous reset
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q      <= IDLE;
      op_q         <= 2'b00;
      tx_q         <= '0;
      cap_q        <= '0;
      cnt_q        <= '0;
      rdata        <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      wse_outputs  <= 1'b0;
      hold_outputs <= 1'b0;
      WPSI0        <= 1'b0;
    end else begin
      state_q      <= state_d;
      op_q         <= op_d;
      tx_q         <= tx_d;
      cap_q        <= cap_d;
      cnt_q        <= cnt_d;
      rdata        <= rdata_d;
      busy         <= busy_d;
      done         <= done_d;
      wse_outputs  <= wse_d;
      hold_outputs <= hold_d;
      WPSI0        <= wpsi_d;
    end
  end

  // Next-state and next-output logic; outputs are computed for the next state
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tx_d    = tx_q;
    cap_d   = cap_q;
    cnt_d   = cnt_q;
    rdata_d = rdata;
    busy_d  = busy;
    done_d  = 1'b0;
    wse_d   = 1'b0;
    hold_d  = hold_outputs;
    wpsi_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d   = op;
          tx_d   = wdata;
          busy_d = 1'b1;
          unique case (op)
            OP_SHIFT: begin
              state_d = SHIFT;
              cnt_d   = '0;
              wse_d   = 1'b1;
              hold_d  = 1'b1;
              wpsi_d  = wdata[WBR_LEN-1];
            end
            OP_CSHIFT, OP_CAPTURE: begin
              state_d = CAPT;
              hold_d  = 1'b0;
            end
            OP_RELEASE: begin
              state_d = DONE;
              done_d  = 1'b1;
              hold_d  = 1'b0;
            end
            default: state_d = IDLE;
          endcase
        end
      end

      CAPT: begin
        if (op_q == OP_CSHIFT) begin
          state_d = SHIFT;
          cnt_d   = '0;
          wse_d   = 1'b1;
          hold_d  = 1'b1;
          wpsi_d  = tx_q[WBR_LEN-1];
        end else begin
          state_d = DONE;
          done_d  = 1'b1;
          hold_d  = 1'b1;
        end
      end

      SHIFT: begin
        // This edge shifts the chain: capture WPSO0, advance the transmit word
        cap_d = (cap_q << 1) | {{(WBR_LEN-1){1'b0}}, WPSO0};
        tx_d  = tx_q << 1;
        if (cnt_q == CNT_LAST) begin
          state_d = DONE;
          done_d  = 1'b1;
          hold_d  = 1'b1;
          rdata_d = cap_d;
        end else begin
          cnt_d  = cnt_q + CNT_ONE;
          wse_d  = 1'b1;
          hold_d = 1'b1;
          wpsi_d = tx_q[WBR_LEN-2];
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wbr_access_ctrl.sv
// Self-checking bench for wbr_access_ctrl: a behavioural WBR chain, a
// high-level operation model feeding a scoreboard, and a done-pulse monitor.
module tb_wbr_access_ctrl;

  localparam int unsigned W  = 7;
  localparam int unsigned CW = 4;

  logic         CLK = 1'b0;
  logic         reset, start;
  logic [1:0]   op;
  logic [W-1:0] wdata, rdata;
  logic         busy, done, wse_outputs, hold_outputs, WPSI0, WPSO0;

  logic [W-1:0] chain;
  logic [W-1:0] core_out;
  int unsigned  cyc = 0;
  int           tests = 0;
  int           fails = 0;

  typedef struct {
    logic [W-1:0] rdata;
    logic [W-1:0] chain;
    logic [W-1:0] wdata;
    logic         hold;
    logic         chk_chain;
    int unsigned  lat;
    int unsigned  wse_n;
    int unsigned  issue;
  } exp_t;

  exp_t sb[$];

  // Abstract view of the wrapper as seen by the sequencer
  logic         hold_ref;
  logic [W-1:0] chain_ref, rdata_ref;

  wbr_access_ctrl #(.WBR_LEN(W), .CNT_W(CW)) dut (
    .CLK(CLK), .reset(reset), .start(start), .op(op), .wdata(wdata),
    .rdata(rdata), .busy(busy), .done(done), .wse_outputs(wse_outputs),
    .hold_outputs(hold_outputs), .WPSI0(WPSI0), .WPSO0(WPSO0)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Behavioural WBR chain: cell 0 next to WPSI0, cell W-1 next to WPSO0
  always @(posedge CLK) begin
    if (wse_outputs)       chain <= {chain[W-2:0], WPSI0};
    else if (!hold_outputs) chain <= core_out;
  end
  assign WPSO0 = chain[W-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: track shift activity per operation and score each done pulse
  int unsigned  wse_n = 0;
  logic [W-1:0] tx_seen = '0;
  exp_t         m;
  always @(negedge CLK) begin
    if (wse_outputs) chk("wse_implies_hold", 32'(hold_outputs), 32'd1);
    if (!busy) begin
      wse_n   = 0;
      tx_seen = '0;
    end else if (wse_outputs) begin
      wse_n++;
      tx_seen = {tx_seen[W-2:0], WPSI0};
    end
    if (done) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        m = sb.pop_front();
        chk("rdata", 32'(rdata), 32'(m.rdata));
        chk("hold_at_done", 32'(hold_outputs), 32'(m.hold));
        chk("busy_at_done", 32'(busy), 32'd1);
        chk("latency", cyc - m.issue, m.lat);
        chk("wse_cycles", wse_n, m.wse_n);
        if (m.wse_n != 0) chk("wpsi_sequence", 32'(tx_seen), 32'(m.wdata));
        if (m.chk_chain)  chk("chain_content", 32'(chain), 32'(m.chain));
      end
    end
  end

  // Issue one operation at a negedge, predict its outcome, optionally pulse
  // stray starts while busy and on the done cycle; returns at the idle cycle.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] wd, input bit noise);
    exp_t         e;
    int unsigned  len;
    logic [W-1:0] pre;
    pre         = hold_ref ? chain_ref : core_out;
    e.wdata     = wd;
    e.issue     = cyc;
    e.rdata     = rdata_ref;
    e.chain     = chain_ref;
    e.chk_chain = 1'b1;
    e.wse_n     = 0;
    e.hold      = (o != 2'b11);
    case (o)
      2'b00: begin len = W + 1; e.rdata = pre;      e.chain = wd;       e.wse_n = W; end
      2'b01: begin len = W + 2; e.rdata = core_out; e.chain = wd;       e.wse_n = W; end
      2'b10: begin len = 2;                         e.chain = core_out;              end
      default: begin len = 1;   e.chk_chain = 1'b0;                                  end
    endcase
    e.lat     = len;
    hold_ref  = e.hold;
    rdata_ref = e.rdata;
    chain_ref = (o == 2'b11) ? core_out : e.chain;
    sb.push_back(e);
    start = 1'b1;
    op    = o;
    wdata = wd;
    for (int i = 1; i <= int'(len); i++) begin
      @(negedge CLK);
      start = noise && (i == int'(len) || $urandom_range(0, 2) == 0);
      op    = 2'($urandom);
      wdata = W'($urandom);
    end
    @(negedge CLK);
    start = 1'b0;
    chk("busy_idle", 32'(busy), 32'd0);
  endtask

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  // Stimulus
  initial begin
    reset     = 1'b1;
    start     = 1'b0;
    op        = 2'b00;
    wdata     = '0;
    core_out  = 7'b0110101;
    hold_ref  = 1'b0;
    chain_ref = '0;
    rdata_ref = '0;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    @(negedge CLK);
    chk("reset_wse",   32'(wse_outputs),  32'd0);
    chk("reset_hold",  32'(hold_outputs), 32'd0);
    chk("reset_busy",  32'(busy),         32'd0);
    chk("reset_done",  32'(done),         32'd0);
    chk("reset_rdata", 32'(rdata),        32'd0);
    chk("reset_wpsi",  32'(WPSI0),        32'd0);

    // SHIFT against a chain holding 0110101
    issue(2'b00, 7'b1011001, 1'b0);
    // CAPTURE_SHIFT with core outputs 1110000
    core_out = 7'b1110000;
    issue(2'b01, 7'b0001111, 1'b0);
    // Stray starts during SHIFT and on done, then an immediate accepted start
    issue(2'b00, 7'b1100110, 1'b1);
    issue(2'b10, 7'b0000000, 1'b0);
    // RELEASE after SHIFT
    issue(2'b00, 7'b0101010, 1'b0);
    issue(2'b11, 7'b1111111, 1'b0);

    // Reset during the third shift cycle
    core_out = 7'b0011100;
    start = 1'b1;
    op    = 2'b00;
    wdata = 7'b1110001;
    @(negedge CLK);
    start = 1'b0;
    repeat (2) @(negedge CLK);
    reset = 1'b1;
    @(negedge CLK);
    reset = 1'b0;
    chk("midreset_wse",   32'(wse_outputs),  32'd0);
    chk("midreset_hold",  32'(hold_outputs), 32'd0);
    chk("midreset_busy",  32'(busy),         32'd0);
    chk("midreset_done",  32'(done),         32'd0);
    chk("midreset_rdata", 32'(rdata),        32'd0);
    hold_ref  = 1'b0;
    rdata_ref = '0;
    repeat (3) @(negedge CLK);
    issue(2'b00, 7'b1001011, 1'b0);

    // Randomized operation mix
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) core_out = W'($urandom);
      issue(2'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (4) @(negedge CLK);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
